// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the RV32 data memory / load-store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Byte enables for a store of the given size starting at the given byte lane.
    function automatic logic [3:0] be_gen(input size_e size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = 4'b0011 << lane;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input size_e size,
                                             input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            SZ_W:    r = word;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port DEPTH x 32 block RAM with byte enables and a registered read port.
module dmem_bram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    (* ram_style = "block" *) logic [31:0] mem [DEPTH];

    // Byte-lane writes plus a synchronous read; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory: request decode, lane handling, error flagging and post-reset zero fill.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 4096,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    state_e        state;
    state_e        state_next;
    logic [AW-1:0] clr_idx;

    size_e         req_sz;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic          err;
    logic          accept;
    logic [31:0]   st_data;

    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          p_valid;
    logic          p_we;
    logic          p_err;
    size_e         p_size;
    logic [1:0]    p_lane;
    logic          p_uns;

    assign req_ready = (state == ST_RUN);
    assign busy      = ~req_ready;

    assign req_sz   = size_e'(req_size);
    assign lane     = req_addr[1:0];
    assign word_idx = req_addr[AW+1:2];
    assign accept   = req_valid & req_ready;

    // Flag illegal size, misalignment for the access width, and word index past the array.
    always_comb begin
        err = 1'b0;
        if (req_sz == SZ_ILL)                          err = 1'b1;
        if (req_sz == SZ_H && req_addr[0])             err = 1'b1;
        if (req_sz == SZ_W && req_addr[1:0] != 2'b00)  err = 1'b1;
        if (req_addr[31:2] >= 30'(DEPTH))              err = 1'b1;
    end

    // Replicate narrow store data across lanes so the byte enables pick the right copy.
    always_comb begin
        st_data = req_wdata;
        case (req_sz)
            SZ_B:    st_data = {4{req_wdata[7:0]}};
            SZ_H:    st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

    // RAM port is owned by the zero-fill while clearing, by requests otherwise.
    always_comb begin
        ram_addr  = word_idx;
        ram_we    = 4'b0000;
        ram_wdata = st_data;
        if (state == ST_CLEAR) begin
            ram_addr  = clr_idx;
            ram_wdata = 32'b0;
            ram_we    = rst ? 4'b0000 : 4'b1111;
        end else if (accept && req_we && !err && !rst) begin
            ram_we = be_gen(req_sz, lane);
        end
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_idx == AW'(DEPTH - 1)) begin
            state_next = ST_RUN;
        end
    end

    // State register and clear index; a reset always restarts the fill from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // Carry request attributes alongside the RAM read so the response lines up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_we    <= 1'b0;
            p_err   <= 1'b0;
            p_size  <= SZ_B;
            p_lane  <= 2'b00;
            p_uns   <= 1'b0;
        end else begin
            p_valid <= accept;
            p_we    <= req_we;
            p_err   <= err;
            p_size  <= req_sz;
            p_lane  <= lane;
            p_uns   <= req_unsigned;
        end
    end

    dmem_bram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_valid = p_valid;
    assign rsp_err   = p_valid & p_err;
    assign rsp_rdata = (p_valid && !p_err && !p_we) ? load_ext(ram_rdata, p_size, p_lane, p_uns)
                                                    : 32'b0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a 64-word array and zero fill enabled.
module tb_dmem_lsu;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int run_len = 0;
    int max_run = 0;
    int rsp_id  = 0;

    logic [31:0] q_rdata [$];
    logic        q_err   [$];

    dmem_lsu #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request (called just after a rising edge) and queue its expected response.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        q_rdata.push_back(exp_rdata);
        q_err.push_back(exp_err);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count cycles until ready rises, starting in the first cycle with rst low.
    task automatic wait_ready(input string name, input int expect_cycles);
        int cycles;
        cycles = 0;
        checkOutput({name, "_busy_first"}, {31'b0, busy}, 32'd1);
        while (!req_ready && cycles < 4 * DEPTH) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({name, "_ready_cycles"}, cycles, expect_cycles);
        checkOutput({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    // Monitor: pop and compare an expectation for every presented response.
    always @(negedge clk) begin
        if (rsp_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (q_rdata.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                checkOutput($sformatf("rsp%0d_rdata", rsp_id), rsp_rdata, q_rdata.pop_front());
                checkOutput($sformatf("rsp%0d_err", rsp_id), {31'b0, rsp_err},
                            {31'b0, q_err.pop_front()});
                rsp_id++;
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        wait_ready("init", DEPTH);

        $display("[TB] zero-fill readback");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0);
        end

        $display("[TB] sub-word stores and extension");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000F0, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h11F03344, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'hFFFFFFF0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'h000000F0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h00000011, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'h00000033, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h000011F0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 32'h00003344, 1'b0);

        $display("[TB] halfword stores");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'hFFFF8001, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h00008001, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h80010000, 1'b0);

        $display("[TB] error cases");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555, 32'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h80010000, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'hDEADBEEF, 32'd0, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 32'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h11F03344, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000007F, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'd0, 32'h0000007F, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h7F010000, 1'b0);

        repeat (3) @(posedge clk);
        #1;

        $display("[TB] back-to-back throughput");
        max_run = 0;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A50001, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'hA5A50001, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h5A5A0002, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h5A5A0002, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h00FF0003, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h00FF0003, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'hFF000004, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'hFF000004, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("burst_run_length", max_run, 32'd8);

        $display("[TB] reset during a pending load");
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        checkOutput("pending_drop_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        wait_ready("pending", DEPTH);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);

        $display("[TB] reset during clear at index 30");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("midclear_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("midclear_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midclear_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        wait_ready("midclear", DEPTH);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", q_rdata.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised RV32 data memory with integrated load/store lane handling. It sits between the core's memory stage and an inferred block RAM, and accepts one load or store per cycle over a valid/ready request port. Stores of byte, halfword and word size are committed through byte enables; loads are returned as sign- or zero-extended values. Misaligned and out-of-range accesses are flagged, and the whole array is cleared by a sequential FSM after reset.

## Interface
- DEPTH, 4096, number of 32-bit words; power of two, ≥ 4.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = skip it.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or out of range.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: CLEAR and RUN.
- On rst:
  - State goes to CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
  - Clear index resets to 0.
  - Outputs reset to: rsp_valid 0, rsp_rdata 0, rsp_err 0.
- CLEAR state:
  - Each non-reset cycle writes mem[idx] = 0 and increments idx.
  - After the write of DEPTH-1, the next state is RUN.
  - req_ready = 0 and busy = 1 throughout CLEAR.
- RUN state: req_ready = 1 and busy = 0.
- Accept = req_valid & req_ready.
- Word index = req_addr[$clog2(DEPTH)+1:2]; lane = req_addr[1:0].
- Error conditions, any of:
  - req_size = 11.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
  - req_addr[31:2] ≥ DEPTH.
- An erroring request performs no write. Its response has rsp_err = 1 and rsp_rdata = 0.
- Store byte enables and data placement:
  - Byte: enable = 1 << lane; wdata[7:0] replicated to all four lanes.
  - Half: enable = 0011 << lane; wdata[15:0] replicated to both halves.
  - Word: enable = 1111.
- Load extraction:
  - Select byte or half by the registered lane and size.
  - Sign-extend from bit 7 or bit 15 unless req_unsigned is set.
  - Word loads are passed through unchanged.
- Lane, size, unsigned and err are registered alongside the RAM read to meet the 1-cycle latency.
- No response backpressure: the consumer always accepts rsp.
- Reset mid-operation:
  - Any pending response is dropped (rsp_valid = 0 on the next edge).
  - The clear sequence restarts at index 0.
  - A partially written store is not guaranteed to persist.

## Timing
- Request accepted at edge N: rsp_valid = 1 during cycle N+1, for exactly one cycle.
- Back-to-back accepts give back-to-back responses, with full throughput of 1 request per cycle.
- A store at edge N followed by a load of the same word at edge N+1 returns the new data.
- Read-first behaviour within a cycle is irrelevant, because only one access occurs per cycle.
- With CLEAR_ON_RESET = 1: req_ready first rises exactly DEPTH cycles after the first cycle in which rst is low.
- With CLEAR_ON_RESET = 0: req_ready rises in the first cycle after rst is low.
- busy is the exact complement of req_ready.

## Structure
- Package dmem_pkg holds:
  - The size enum (SZ_B, SZ_H, SZ_W, SZ_ILL).
  - The FSM state enum.
  - Function be_gen(size, lane) returning 4 bits.
  - Function load_ext(word, size, lane, unsigned) returning 32 bits.
- Sub-module dmem_bram:
  - DEPTH x 32 array with ram_style "block".
  - One address, 4-bit byte enable, write data, and registered read data.
  - No reset on the array contents.
- dmem_lsu contains the FSM, clear counter, request decode, error logic and response pipeline register. The clear sequence drives dmem_bram through a mux.

## Test plan
- Reset with DEPTH = 64 and CLEAR_ON_RESET = 1:
  - req_ready stays low for 64 cycles after rst drops.
  - Afterwards, LW of every word returns 0 with rsp_err = 0.
- Sub-word stores and sign extension:
  - SW 0x11223344 @0x10, then SB 0xF0 @0x12.
  - LW @0x10 → 0x11F03344.
  - LB @0x12 → 0xFFFFFFF0.
  - LBU @0x12 → 0x000000F0.
- Halfword stores and loads:
  - SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001.
  - LHU @0x22 → 0x00008001.
  - LW @0x20 → 0x80010000.
- Misalignment and range errors:
  - SH @0x21 → rsp_err = 1; a later LW @0x20 is unchanged.
  - LW @(DEPTH*4) → rsp_err = 1, rsp_rdata = 0.
  - req_size = 11 → rsp_err = 1.
- Throughput: 8 consecutive accepts (alternating SW and LW to the same address) → 8 consecutive rsp_valid pulses, each LW returning the data just stored.
- Reset mid-operation:
  - Assert rst during CLEAR at idx = 30, and separately during a pending load.
  - rsp_valid is 0 next cycle, the clear restarts, and ready is delayed a full DEPTH cycles.
